// File: rtl/radar_gate_gen.sv
// radar_gate_gen: programmable radar transmit/receive gate generator.
// A serial register bank sets the inter-pulse period (IPP), the transmit
// pulse width and the receive window. A small FSM sequences IPPs either
// back-to-back (internal mode) or one per external trigger edge. All
// gate outputs come straight from flops and line up with the phase counter.

module radar_gate_gen #(
    parameter logic [6:0] BASE = 7'd64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        serial_strobe,
    input  logic [6:0]  serial_addr,
    input  logic [31:0] serial_data,
    input  logic        ext_trig,
    output logic        tx_pulse,
    output logic        rx_gate,
    output logic        ipp_start,
    output logic [15:0] ipp_count,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [6:0] ADDR_CTRL     = BASE;
    localparam logic [6:0] ADDR_IPP_LEN  = BASE + 7'd1;
    localparam logic [6:0] ADDR_TX_WIDTH = BASE + 7'd2;
    localparam logic [6:0] ADDR_RX_DELAY = BASE + 7'd3;
    localparam logic [6:0] ADDR_RX_WIDTH = BASE + 7'd4;

    // Control register: bit 0 run, bit 1 ext_mode, bit 2 single_shot.
    logic [2:0]  ctrl_q, ctrl_d;
    logic [23:0] ipp_len_q, ipp_len_d;
    logic [15:0] tx_width_q, tx_width_d;
    logic [23:0] rx_delay_q, rx_delay_d;
    logic [23:0] rx_width_q, rx_width_d;

    // Per-IPP copies, so writes made mid-IPP only affect the next IPP.
    logic [23:0] len_sh_q, len_sh_d;
    logic [15:0] tx_sh_q, tx_sh_d;
    logic [23:0] rxd_sh_q, rxd_sh_d;
    logic [23:0] rxw_sh_q, rxw_sh_d;

    // External trigger: two synchronizer stages plus one history stage.
    logic [2:0]  trig_sync_q, trig_sync_d;
    logic        trig_edge_q, trig_edge_d;

    state_t      state_q, state_d;
    logic [23:0] phase_q, phase_d;
    logic [15:0] count_q, count_d;
    logic        tx_q, tx_d;
    logic        rx_q, rx_d;
    logic        start_q, start_d;
    logic        busy_q, busy_d;

    logic        run_now;
    logic        run_next;
    logic        ext_mode;
    logic        single_shot;
    logic        ipp_last;
    logic        new_ipp;
    logic [23:0] len_clamped;
    logic [24:0] rx_end_d;

    // Upper write-data bits have no destination register.
    logic        unused_data;
    assign unused_data = &{1'b0, serial_data[31:24]};

    // Serial register write decode; a write lands in the register at the next edge.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
        ctrl_d     = ctrl_q;
        ipp_len_d  = ipp_len_q;
        tx_width_d = tx_width_q;
        rx_delay_d = rx_delay_q;
        rx_width_d = rx_width_q;
        if (serial_strobe) begin
            if (serial_addr == ADDR_CTRL) begin
                ctrl_d = serial_data[2:0];
            end else if (serial_addr == ADDR_IPP_LEN) begin
                ipp_len_d = serial_data[23:0];
            end else if (serial_addr == ADDR_TX_WIDTH) begin
                tx_width_d = serial_data[15:0];
            end else if (serial_addr == ADDR_RX_DELAY) begin
                rx_delay_d = serial_data[23:0];
            end else if (serial_addr == ADDR_RX_WIDTH) begin
                rx_width_d = serial_data[23:0];
            end
        end
    end

    // Mode bits. Starting uses the registered run bit (so the first IPP
    // begins two cycles after the write), while stopping looks at the value
    // being written so a clearing write shuts the outputs off one cycle later.
    assign run_now     = ctrl_q[0];
    assign run_next    = ctrl_d[0];
    assign ext_mode    = ctrl_q[1];
    assign single_shot = ctrl_q[2];

    assign len_clamped = (ipp_len_q < 24'd2) ? 24'd2 : ipp_len_q;
    assign ipp_last    = (phase_q == (len_sh_q - 24'd1));

    // Trigger synchronizer shift and registered rising-edge detect.
    always_comb begin
        trig_sync_d = {trig_sync_q[1:0], ext_trig};
        trig_edge_d = trig_sync_q[1] & ~trig_sync_q[2];
    end

    // FSM next-state logic; new_ipp marks that the next cycle is phase 0 of an IPP.
    always_comb begin
        state_d = state_q;
        new_ipp = 1'b0;
        if (!run_next) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (run_now) begin
                        if (ext_mode) begin
                            state_d = ARM;
                        end else begin
                            state_d = RUN;
                            new_ipp = 1'b1;
                        end
                    end
                end
                ARM: begin
                    if (trig_edge_q) begin
                        state_d = RUN;
                        new_ipp = 1'b1;
                    end
                end
                RUN: begin
                    if (ipp_last) begin
                        if (single_shot) begin
                            state_d = HOLD;
                        end else if (ext_mode) begin
                            state_d = ARM;
                        end else begin
                            state_d = RUN;
                            new_ipp = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    state_d = HOLD;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Phase counter, shadow capture and gate decode for the upcoming cycle.
    always_comb begin
        len_sh_d = len_sh_q;
        tx_sh_d  = tx_sh_q;
        rxd_sh_d = rxd_sh_q;
        rxw_sh_d = rxw_sh_q;
        phase_d  = '0;
        if (new_ipp) begin
            len_sh_d = len_clamped;
            tx_sh_d  = tx_width_q;
            rxd_sh_d = rx_delay_q;
            rxw_sh_d = rx_width_q;
        end else if (state_d == RUN) begin
            phase_d = phase_q + 24'd1;
        end

        // Phase never reaches len_sh, so both windows are clipped at the IPP end.
        rx_end_d = {1'b0, rxd_sh_d} + {1'b0, rxw_sh_d};
        tx_d     = (state_d == RUN) && (phase_d < {8'd0, tx_sh_d});
        rx_d     = (state_d == RUN) && (phase_d >= rxd_sh_d)
                   && ({1'b0, phase_d} < rx_end_d);
        start_d  = new_ipp;
        busy_d   = (state_d != IDLE);
    end

    // IPP counter: cleared on a run 0->1 write, bumped in the last cycle of each IPP.
    always_comb begin
        count_d = count_q;
        if (run_next && !run_now) begin
            count_d = '0;
        end else if ((state_q == RUN) && ipp_last) begin
            count_d = count_q + 16'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        // NOTE: clocked blocks use non-blocking (<=) so every flop samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Register bank, shadows, synchronizer and output flops; reset wins over a same-cycle write.
    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_q      <= '0;
            ipp_len_q   <= '0;
            tx_width_q  <= '0;
            rx_delay_q  <= '0;
            rx_width_q  <= '0;
            len_sh_q    <= '0;
            tx_sh_q     <= '0;
            rxd_sh_q    <= '0;
            rxw_sh_q    <= '0;
            trig_sync_q <= '0;
            trig_edge_q <= 1'b0;
            phase_q     <= '0;
            count_q     <= '0;
            tx_q        <= 1'b0;
            rx_q        <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            ctrl_q      <= ctrl_d;
            ipp_len_q   <= ipp_len_d;
            tx_width_q  <= tx_width_d;
            rx_delay_q  <= rx_delay_d;
            rx_width_q  <= rx_width_d;
            len_sh_q    <= len_sh_d;
            tx_sh_q     <= tx_sh_d;
            rxd_sh_q    <= rxd_sh_d;
            rxw_sh_q    <= rxw_sh_d;
            trig_sync_q <= trig_sync_d;
            trig_edge_q <= trig_edge_d;
            phase_q     <= phase_d;
            count_q     <= count_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
        end
    end

    assign tx_pulse  = tx_q;
    assign rx_gate   = rx_q;
    assign ipp_start = start_q;
    assign ipp_count = count_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_radar_gate_gen.sv
// Testbench for radar_gate_gen. Expected IPP profiles (start cycle, gate
// counts and window edges) are queued when the stimulus is driven and
// compared by a monitor as each IPP is observed on the outputs.
`timescale 1ns/1ps

module tb_radar_gate_gen;

    localparam logic [6:0] BASE = 7'd64;

    logic        clock = 1'b0;
    logic        reset;
    logic        serial_strobe;
    logic [6:0]  serial_addr;
    logic [31:0] serial_data;
    logic        ext_trig;
    logic        tx_pulse;
    logic        rx_gate;
    logic        ipp_start;
    logic [15:0] ipp_count;
    logic        busy;

    radar_gate_gen #(.BASE(BASE)) dut (
        .clock         (clock),
        .reset         (reset),
        .serial_strobe (serial_strobe),
        .serial_addr   (serial_addr),
        .serial_data   (serial_data),
        .ext_trig      (ext_trig),
        .tx_pulse      (tx_pulse),
        .rx_gate       (rx_gate),
        .ipp_start     (ipp_start),
        .ipp_count     (ipp_count),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    int wr_cyc   = 0;

    typedef struct {
        int start;
        int len;
        int tx_cnt;
        int tx_last;
        int rx_cnt;
        int rx_first;
        int rx_last;
    } ipp_exp_t;

    ipp_exp_t exp_q[$];
    ipp_exp_t cur;
    bit       mon_open = 1'b0;
    int       ipp_idx  = 0;
    int       m_ph, m_tx_cnt, m_tx_last, m_rx_cnt, m_rx_first, m_rx_last;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference profile of one IPP, measured over its first 'meas' cycles.
    task automatic push_ipp(input int start, input int meas, input int len,
                            input int txw, input int rxd, input int rxw);
        ipp_exp_t e;
        int eff;
        eff        = (len < 2) ? 2 : len;
        e.start    = start;
        e.len      = meas;
        e.tx_cnt   = 0;
        e.tx_last  = -1;
        e.rx_cnt   = 0;
        e.rx_first = -1;
        e.rx_last  = -1;
        for (int p = 0; p < meas; p++) begin
            if (p < txw) begin
                e.tx_cnt++;
                e.tx_last = p;
            end
            if (p >= rxd && p < rxd + rxw && p < eff) begin
                if (e.rx_first < 0) e.rx_first = p;
                e.rx_last = p;
                e.rx_cnt++;
            end
        end
        exp_q.push_back(e);
    endtask

    // Monitor: opens a measurement on each ipp_start and scores it once the expected span is seen.
    always @(negedge clock) begin
        if (ipp_start === 1'b1) begin
            if (mon_open) begin
                check($sformatf("ipp%0d_start_early", ipp_idx), cyc, cur.start + cur.len);
                mon_open = 1'b0;
            end
            if (exp_q.size() == 0) begin
                check("unexpected_ipp_start", 64'(ipp_start), 0);
            end else begin
                cur = exp_q.pop_front();
                ipp_idx++;
                mon_open   = 1'b1;
                m_ph       = 0;
                m_tx_cnt   = 0;
                m_tx_last  = -1;
                m_rx_cnt   = 0;
                m_rx_first = -1;
                m_rx_last  = -1;
                check($sformatf("ipp%0d_start_cycle", ipp_idx), cyc, cur.start);
            end
        end
        if (mon_open) begin
            if (tx_pulse === 1'b1) begin
                m_tx_cnt++;
                m_tx_last = m_ph;
            end
            if (rx_gate === 1'b1) begin
                if (m_rx_first < 0) m_rx_first = m_ph;
                m_rx_last = m_ph;
                m_rx_cnt++;
            end
            m_ph++;
            if (m_ph == cur.len) begin
                check($sformatf("ipp%0d_tx_cnt", ipp_idx), m_tx_cnt, cur.tx_cnt);
                check($sformatf("ipp%0d_tx_last", ipp_idx), m_tx_last, cur.tx_last);
                check($sformatf("ipp%0d_rx_cnt", ipp_idx), m_rx_cnt, cur.rx_cnt);
                check($sformatf("ipp%0d_rx_first", ipp_idx), m_rx_first, cur.rx_first);
                check($sformatf("ipp%0d_rx_last", ipp_idx), m_rx_last, cur.rx_last);
                mon_open = 1'b0;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) next_cycle();
    endtask

    task automatic at_neg();
        @(negedge clock);
    endtask

    task automatic wr_raw(input logic [6:0] a, input logic [31:0] d);
        next_cycle();
        serial_strobe = 1'b1;
        serial_addr   = a;
        serial_data   = d;
        wr_cyc        = cyc;
        next_cycle();
        serial_strobe = 1'b0;
    endtask

    task automatic wr(input int off, input int d);
        wr_raw(BASE + 7'(off), 32'(d));
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_tx"}, 64'(tx_pulse), 0);
        check({tag, "_rx"}, 64'(rx_gate), 0);
        check({tag, "_start"}, 64'(ipp_start), 0);
        check({tag, "_busy"}, 64'(busy), 0);
    endtask

    task automatic check_pending(input string tag);
        check({tag, "_pending"}, exp_q.size(), 0);
        check({tag, "_open"}, 64'(mon_open), 0);
    endtask

    // Internal-mode run: n_full complete IPPs, then stop in phase 1 of the next one.
    task automatic run_internal(input string tag, input int n_full, input int len,
                                input int txw, input int rxd, input int rxw);
        int s;
        int eff;
        eff = (len < 2) ? 2 : len;
        wr(0, 1);
        s = wr_cyc;
        at_neg();
        check({tag, "_count_cleared"}, 64'(ipp_count), 0);
        for (int k = 0; k < n_full; k++) push_ipp(s + 2 + k * eff, eff, len, txw, rxd, rxw);
        push_ipp(s + 2 + n_full * eff, 2, len, txw, rxd, rxw);
        goto(s + 2 + n_full * eff);
        at_neg();
        check({tag, "_count"}, 64'(ipp_count), n_full);
        check({tag, "_busy_run"}, 64'(busy), 1);
        wr(0, 0);
        at_neg();
        expect_idle({tag, "_stop"});
        check_pending(tag);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        int t;
        int t2;

        reset         = 1'b1;
        serial_strobe = 1'b0;
        serial_addr   = '0;
        serial_data   = '0;
        ext_trig      = 1'b0;

        // Reset, with a run write landing in the last reset cycle (must be lost).
        repeat (3) next_cycle();
        serial_strobe = 1'b1;
        serial_addr   = BASE;
        serial_data   = 32'd1;
        next_cycle();
        serial_strobe = 1'b0;
        reset         = 1'b0;
        at_neg();
        expect_idle("reset");
        check("reset_count", 64'(ipp_count), 0);
        goto(cyc + 5);
        at_neg();
        expect_idle("write_lost");

        // Config writes and unmapped addresses leave the block idle.
        wr(1, 100);
        wr(2, 10);
        wr(3, 20);
        wr(4, 50);
        wr_raw(BASE + 7'd5, 32'd1);
        wr_raw(BASE - 7'd1, 32'd1);
        goto(cyc + 4);
        at_neg();
        expect_idle("no_run");
        check("no_run_count", 64'(ipp_count), 0);

        // Internal mode: 100-cycle IPPs, tx 10 cycles, rx phases 20..69.
        run_internal("int", 3, 100, 10, 20, 50);

        // External mode: ipp_len 50, trigger edges start IPPs, edge during RUN ignored.
        wr(1, 50);
        wr(0, 3);
        s = wr_cyc;
        at_neg();
        check("ext_count_cleared", 64'(ipp_count), 0);
        goto(s + 4);
        at_neg();
        check("ext_armed_busy", 64'(busy), 1);
        next_cycle();
        ext_trig = 1'b1;
        t = cyc;
        push_ipp(t + 4, 50, 50, 10, 20, 50);
        goto(t + 5);
        ext_trig = 1'b0;
        goto(t + 20);
        ext_trig = 1'b1;
        goto(t + 25);
        ext_trig = 1'b0;
        goto(t + 60);
        at_neg();
        check("ext_arm_busy", 64'(busy), 1);
        check("ext_count1", 64'(ipp_count), 1);
        goto(t + 80);
        ext_trig = 1'b1;
        t2 = cyc;
        push_ipp(t2 + 4, 50, 50, 10, 20, 50);
        goto(t2 + 5);
        ext_trig = 1'b0;
        goto(t2 + 60);
        at_neg();
        check("ext_rearm_busy", 64'(busy), 1);
        check("ext_count2", 64'(ipp_count), 2);
        check_pending("ext");
        wr(0, 0);
        at_neg();
        expect_idle("ext_stop");

        // Single shot: one 40-cycle IPP, then HOLD until run is cleared.
        wr(1, 40);
        wr(0, 5);
        s = wr_cyc;
        at_neg();
        check("ss_count_cleared", 64'(ipp_count), 0);
        push_ipp(s + 2, 40, 40, 10, 20, 50);
        goto(s + 60);
        at_neg();
        check("ss_hold_busy", 64'(busy), 1);
        check("ss_count", 64'(ipp_count), 1);
        check_pending("ss");
        wr(0, 0);
        at_neg();
        expect_idle("ss_stop");

        // Boundaries: ipp_len 1 -> 2-cycle IPPs; wide tx; clipped rx; rx past the end.
        wr(1, 1);
        run_internal("len1", 3, 1, 10, 20, 50);
        wr(1, 100);
        wr(2, 200);
        wr(3, 90);
        wr(4, 50);
        run_internal("wide", 2, 100, 200, 90, 50);
        wr(3, 100);
        run_internal("late_rx", 1, 100, 200, 100, 50);

        // Mid-IPP rx_delay update applies from the next IPP; abort mid tx pulse.
        wr(2, 10);
        wr(3, 20);
        wr(4, 50);
        wr(0, 1);
        s = wr_cyc;
        at_neg();
        check("upd_count_cleared", 64'(ipp_count), 0);
        push_ipp(s + 2, 100, 100, 10, 20, 50);
        push_ipp(s + 102, 100, 100, 10, 30, 50);
        push_ipp(s + 202, 6, 100, 10, 30, 50);
        goto(s + 11);
        wr(3, 30);
        goto(s + 206);
        next_cycle();
        serial_strobe = 1'b1;
        serial_addr   = BASE;
        serial_data   = 32'd0;
        at_neg();
        check("abort_tx_mid_pulse", 64'(tx_pulse), 1);
        next_cycle();
        serial_strobe = 1'b0;
        at_neg();
        expect_idle("abort");
        check("abort_count", 64'(ipp_count), 2);
        check_pending("upd");
        run_internal("rerun", 1, 100, 10, 30, 50);

        // Reset at phase 15 of a running IPP.
        wr(0, 1);
        s = wr_cyc;
        push_ipp(s + 2, 16, 100, 10, 30, 50);
        goto(s + 17);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        at_neg();
        expect_idle("rst_mid");
        check("rst_mid_count", 64'(ipp_count), 0);
        goto(cyc + 5);
        at_neg();
        expect_idle("rst_after");
        check_pending("rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
